// File: rtl/irq_pending_latch.sv
// -----------------------------------------------------------------------------
// irq_pending_latch
//
// Request-capture stage placed in front of the 4-to-2 priority encoder.
// Every request line is synchronized, rising edges are detected, and each
// event is held in a sticky pending bit until the consumer acknowledges it
// by index. The masked pending vector feeds the encoder d_in and the encoder
// d_out comes back as ack_id. Events that arrive while their line is already
// pending are counted as lost and flagged on overflow.
//
// Optional feature macro: IRQ_LATCH_OVF_EN
//   defined     -> per-line sticky overflow detection is built
//   not defined -> overflow is tied to 0 and ovf_clr is ignored
//
// Parameters
//   N            number of request lines (2..32)
//   SYNC_STAGES  synchronizer flops per request line (2..3)
//
// Ports
//   clk        in   1            single clock, rising edge
//   rst        in   1            synchronous, active-high reset
//   req_in     in   N            asynchronous request lines (rising edge = event)
//   mask       in   N            1 hides the pending bit from pend_out
//   pend_out   out  N            pending & ~mask, drives encoder d_in
//   irq_out    out  1            OR-reduce of pend_out
//   ack_valid  in   1            qualifies ack_id for one cycle
//   ack_id     in   clog2(N)     index of the pending bit to clear
//   overflow   out  N            sticky per-line lost-event flags
//   ovf_clr    in   1            clears all overflow flags
// -----------------------------------------------------------------------------
module irq_pending_latch #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_in,
  input  logic [N-1:0]         mask,
  output logic [N-1:0]         pend_out,
  output logic                 irq_out,
  input  logic                 ack_valid,
  input  logic [$clog2(N)-1:0] ack_id,
  output logic [N-1:0]         overflow,
  input  logic                 ovf_clr
);

  localparam int IW = $clog2(N);

  // Synchronizer chain: stage 0 samples req_in, stage SYNC_STAGES-1 is the
  // last synchronized copy that the edge detector looks at.
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                  hist_q;
  logic [N-1:0]                  sync_last;
  logic [N-1:0]                  edge_det;
  logic [N-1:0]                  ack_hit;
  logic [N-1:0]                  pending_q;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Clearing the whole chain and the history flop on reset discards any edge
  // still in flight, and makes a line held high through reset look like a
  // fresh 0->1 transition once reset is released (exactly one event).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist_q <= sync_last;
    end
  end

  assign edge_det = sync_last & ~hist_q;

  // One-hot decode of the acknowledge. An ack_id that does not name a real
  // line (possible when N is not a power of two) matches nothing.
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < N; i++) begin
      if (ack_valid && (ack_id == IW'(i))) begin
        ack_hit[i] = 1'b1;
      end
    end
  end

  // Pending bits: a new edge wins over a same-cycle ack of the same line so
  // that the fresh event is never dropped. Mask plays no part here.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= edge_det | (pending_q & ~ack_hit);
    end
  end

  // Outputs are purely a function of registered pending and the live mask,
  // so a mask change shows up in the same cycle and req_in has no direct path.
  assign pend_out = pending_q & ~mask;
  assign irq_out  = |pend_out;

`ifdef IRQ_LATCH_OVF_EN
  logic [N-1:0] ovf_set;
  logic [N-1:0] overflow_q;

  // An edge on a line that is already pending is merged and lost, unless the
  // same cycle acknowledges that line: then the old event is consumed and the
  // new one takes its place, so nothing is lost.
  assign ovf_set = edge_det & pending_q & ~ack_hit;

  // Sticky flags; a new loss in the same cycle as ovf_clr still registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= '0;
    end else if (ovf_clr) begin
      overflow_q <= ovf_set;
    end else begin
      overflow_q <= overflow_q | ovf_set;
    end
  end

  assign overflow = overflow_q;
`else
  // No loss tracking in this build; ovf_clr stays on the port list but does
  // nothing.
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = '0;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_latch
//
// Self-checking bench for irq_pending_latch (N=4, SYNC_STAGES=2). A
// behavioural model tracks, per line, the history of sampled request values
// and derives events, pending bits and lost-event flags from them. A negedge
// process compares the DUT with the model every cycle; directed scenarios add
// hand-computed literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_irq_pending_latch;

  localparam int N = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_in;
  logic [N-1:0] mask;
  logic [N-1:0] pend_out;
  logic         irq_out;
  logic         ack_valid;
  logic [1:0]   ack_id;
  logic [N-1:0] overflow;
  logic         ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  irq_pending_latch #(
    .N          (N),
    .SYNC_STAGES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .mask     (mask),
    .pend_out (pend_out),
    .irq_out  (irq_out),
    .ack_valid(ack_valid),
    .ack_id   (ack_id),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  // Reference model: samp[j] holds the request vector seen j+1 edges ago;
  // a reset edge wipes the whole history so nothing sampled before it counts.
  // An event is a line whose sample S edges ago is 1 and S+1 edges ago is 0.
  logic [N-1:0] samp [0:S];
  logic [N-1:0] m_pend;
  logic [N-1:0] m_ovf;
  bit           model_valid = 1'b0;

  always @(posedge clk) begin
    logic [N-1:0] ev;
    bit           hit;
    if (rst) begin
      for (int j = 0; j <= S; j++) samp[j] = '0;
      m_pend      = '0;
      m_ovf       = '0;
      model_valid = 1'b1;
    end else begin
      ev = samp[S-1] & ~samp[S];
      for (int i = 0; i < N; i++) begin
        hit = ack_valid && (int'(ack_id) == i);
        if (ovf_clr) m_ovf[i] = 1'b0;
        if (ev[i] && m_pend[i] && !hit) m_ovf[i] = 1'b1;
        if (ev[i]) m_pend[i] = 1'b1;
        else if (hit) m_pend[i] = 1'b0;
      end
      for (int j = S; j > 0; j--) samp[j] = samp[j-1];
      samp[0] = req_in;
    end
  end

  function automatic logic [N-1:0] ovf_exp(input logic [N-1:0] v);
`ifdef IRQ_LATCH_OVF_EN
    return v;
`else
    return '0;
`endif
  endfunction

  function automatic logic [1:0] highest(input logic [N-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic cmp(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      cmp("cyc_pend_out", pend_out, m_pend & ~mask);
      cmp("cyc_irq_out", {3'b000, irq_out}, {3'b000, |(m_pend & ~mask)});
      cmp("cyc_overflow", overflow, ovf_exp(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] rq, input logic [N-1:0] m,
                               input logic av, input logic [1:0] aid, input logic oc);
    rst       = r;
    req_in    = rq;
    mask      = m;
    ack_valid = av;
    ack_id    = aid;
    ovf_clr   = oc;
  endtask

  // Literal expectations: checked against the DUT and against the model.
  task automatic checkOutput(input string name, input logic [N-1:0] e_pend,
                             input logic e_irq, input logic [N-1:0] e_ovf);
    #1;
    cmp({name, "_pend"}, pend_out, e_pend);
    cmp({name, "_irq"}, {3'b000, irq_out}, {3'b000, e_irq});
    cmp({name, "_ovf"}, overflow, ovf_exp(e_ovf));
    cmp({name, "_model"}, m_pend & ~mask, e_pend);
  endtask

  initial begin
    applyStimulus(1'b1, '0, '0, 1'b0, 2'd0, 1'b0);
    ticks(2);
    applyStimulus(1'b0, '0, '0, 1'b0, 2'd0, 1'b0);
    checkOutput("reset", 4'b0000, 1'b0, 4'b0000);

    // Event latency: two edges after first sample.
    applyStimulus(1'b0, 4'b0100, '0, 1'b0, 2'd0, 1'b0);
    tick(); checkOutput("lat_k", 4'b0000, 1'b0, 4'b0000);
    tick(); checkOutput("lat_k1", 4'b0000, 1'b0, 4'b0000);
    tick(); checkOutput("lat_k2", 4'b0100, 1'b1, 4'b0000);

    // Ack drops the bit right after the acking edge.
    applyStimulus(1'b0, 4'b0000, '0, 1'b1, 2'd2, 1'b0);
    tick(); checkOutput("ack_drop", 4'b0000, 1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000, '0, 1'b0, 2'd0, 1'b0);
    ticks(2);

    // Burst drained highest-index-first by the encoder loop.
    applyStimulus(1'b0, 4'b1011, '0, 1'b0, 2'd0, 1'b0);
    ticks(3); checkOutput("burst", 4'b1011, 1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b1011, '0, 1'b1, 2'd3, 1'b0);
    tick(); checkOutput("drain3", 4'b0011, 1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b1011, '0, 1'b1, 2'd1, 1'b0);
    tick(); checkOutput("drain1", 4'b0001, 1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b1011, '0, 1'b1, 2'd0, 1'b0);
    tick(); checkOutput("drain0", 4'b0000, 1'b0, 4'b0000);

    // Lost event on line 1, then ovf_clr.
    applyStimulus(1'b0, 4'b0000, '0, 1'b0, 2'd0, 1'b0);
    ticks(3);
    applyStimulus(1'b0, 4'b0010, '0, 1'b0, 2'd0, 1'b0);
    ticks(3); checkOutput("pend1", 4'b0010, 1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0000, '0, 1'b0, 2'd0, 1'b0);
    ticks(2);
    applyStimulus(1'b0, 4'b0010, '0, 1'b0, 2'd0, 1'b0);
    ticks(3); checkOutput("ovf_set", 4'b0010, 1'b1, 4'b0010);
    applyStimulus(1'b0, 4'b0010, '0, 1'b0, 2'd0, 1'b1);
    tick(); checkOutput("ovf_clr", 4'b0010, 1'b1, 4'b0000);

    // Edge on line 2 coinciding with an ack of line 2.
    applyStimulus(1'b0, 4'b0110, '0, 1'b0, 2'd0, 1'b0);
    ticks(3); checkOutput("pend12", 4'b0110, 1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0010, '0, 1'b0, 2'd0, 1'b0);
    ticks(2);
    applyStimulus(1'b0, 4'b0110, '0, 1'b0, 2'd0, 1'b0);
    ticks(2);
    applyStimulus(1'b0, 4'b0110, '0, 1'b1, 2'd2, 1'b0);
    tick(); checkOutput("edge_vs_ack", 4'b0110, 1'b1, 4'b0000);

    // Mask hides and reveals in the same cycle.
    applyStimulus(1'b0, 4'b0110, '0, 1'b1, 2'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0110, '0, 1'b1, 2'd1, 1'b0);
    tick(); checkOutput("cleared", 4'b0000, 1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0111, '0, 1'b0, 2'd0, 1'b0);
    ticks(3); checkOutput("pend0", 4'b0001, 1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0111, 4'b0001, 1'b0, 2'd0, 1'b0);
    checkOutput("mask_hide", 4'b0000, 1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0111, 4'b0000, 1'b0, 2'd0, 1'b0);
    checkOutput("mask_clear", 4'b0001, 1'b1, 4'b0000);

    // Fill all lines, lose one on line 3, then reset with requests held.
    applyStimulus(1'b0, 4'b1111, '0, 1'b0, 2'd0, 1'b0);
    ticks(3); checkOutput("pend30", 4'b1001, 1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b1001, '0, 1'b0, 2'd0, 1'b0);
    ticks(2);
    applyStimulus(1'b0, 4'b1111, '0, 1'b0, 2'd0, 1'b0);
    ticks(3); checkOutput("pend_all", 4'b1111, 1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0111, '0, 1'b0, 2'd0, 1'b0);
    ticks(2);
    applyStimulus(1'b0, 4'b1111, '0, 1'b0, 2'd0, 1'b0);
    ticks(3); checkOutput("ovf3", 4'b1111, 1'b1, 4'b1000);
    applyStimulus(1'b1, 4'b1111, '0, 1'b0, 2'd0, 1'b0);
    tick(); checkOutput("rst_mid", 4'b0000, 1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b1111, '0, 1'b0, 2'd0, 1'b0);
    tick(); checkOutput("post_rst_k", 4'b0000, 1'b0, 4'b0000);
    tick(); checkOutput("post_rst_k1", 4'b0000, 1'b0, 4'b0000);
    tick(); checkOutput("post_rst_k2", 4'b1111, 1'b1, 4'b0000);
    tick(); checkOutput("post_rst_once", 4'b1111, 1'b1, 4'b0000);

    // Randomized phase; the negedge process does the checking.
    for (int c = 0; c < 3000; c++) begin
      logic         r;
      logic [N-1:0] rq;
      logic [N-1:0] m;
      logic         av;
      logic [1:0]   aid;
      int           sel;
      r  = ($urandom_range(0, 199) == 0);
      rq = ($urandom_range(0, 2) == 0) ? N'($urandom) : req_in;
      m  = ($urandom_range(0, 3) == 0) ? N'($urandom) : mask;
      sel = $urandom_range(0, 3);
      if (sel < 2) begin
        av  = |(m_pend & ~m);
        aid = highest(m_pend & ~m);
      end else if (sel == 2) begin
        av  = 1'b1;
        aid = 2'($urandom);
      end else begin
        av  = 1'b0;
        aid = 2'($urandom);
      end
      applyStimulus(r, rq, m, av, aid, ($urandom_range(0, 15) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
